// File: rtl/crc_pkg.sv
// rtl/crc_pkg.sv - shared CRC-8 defaults, checker state encoding and LFSR next-state function
package crc_pkg;

    localparam int         CRC_MAX_WIDTH = 32;
    localparam logic [7:0] CRC8_SEED     = 8'hD8;
    localparam logic [7:0] CRC8_TAPS     = 8'h44;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PAYLOAD = 2'd1,
        ST_CHECK   = 2'd2
    } chk_state_e;

    // One payload bit into a right-shifting LFSR of the given width.
    // The feedback lands in the top bit; tap bit i XORs feedback into bit i.
    // Generator and checker both call this so their polynomials cannot drift.
    function automatic logic [CRC_MAX_WIDTH-1:0] crc_lfsr_next(
        input logic [CRC_MAX_WIDTH-1:0] lfsr,
        input logic                     d,
        input logic [CRC_MAX_WIDTH-1:0] taps,
        input int                       width
    );
        logic [CRC_MAX_WIDTH-1:0] top_bit;
        logic [CRC_MAX_WIDTH-1:0] keep_mask;
        logic [CRC_MAX_WIDTH-1:0] nxt;
        logic                     fb;
        fb        = d ^ lfsr[0];
        top_bit   = 32'h1 << (width - 1);
        // (top_bit << 1) wraps to zero at full width, giving an all-ones mask
        keep_mask = (top_bit << 1) - 32'h1;
        nxt       = lfsr >> 1;
        if (fb) begin
            nxt = nxt ^ taps;
        end
        nxt = (nxt & ~top_bit) | (fb ? top_bit : 32'h0);
        return nxt & keep_mask;
    endfunction

endpackage

// File: rtl/crc_lfsr_core.sv
// rtl/crc_lfsr_core.sv - CRC LFSR register with load-seed, feed-bit and shift-out controls
// Ports:
//   clk, rst      : clock, synchronous active-high reset (reloads SEED)
//   load_seed     : reload SEED (highest priority after rst)
//   feed_en/bit   : advance the CRC by one data bit
//   shift_en      : shift right with zero fill, exposing the next CRC bit at lfsr[0]
//   lfsr          : current register value
module crc_lfsr_core
    import crc_pkg::*;
#(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] SEED  = CRC8_SEED,
    parameter logic [WIDTH-1:0] TAPS  = CRC8_TAPS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_seed,
    input  logic             feed_en,
    input  logic             feed_bit,
    input  logic             shift_en,
    output logic [WIDTH-1:0] lfsr
);

    logic [CRC_MAX_WIDTH-1:0] feed_next;

    always_comb begin
        feed_next = crc_lfsr_next(CRC_MAX_WIDTH'(lfsr), feed_bit, CRC_MAX_WIDTH'(TAPS), WIDTH);
    end

    always_ff @(posedge clk) begin
        if (rst || load_seed) begin
            lfsr <= SEED;
        end else if (feed_en) begin
            lfsr <= feed_next[WIDTH-1:0];
        end else if (shift_en) begin
            lfsr <= lfsr >> 1;
        end
    end

endmodule

// File: rtl/crc_serial_checker.sv
// rtl/crc_serial_checker.sv - serial CRC frame checker: recompute CRC over payload, compare with received CRC
// Ports:
//   CLK, RST  : clock, synchronous active-high reset
//   SER_IN    : frame bit (payload LSB first, then CRC LSB first)
//   ACTIVE    : high for every bit of a frame
//   P_DATA    : recovered payload, updated with DONE
//   DONE      : one-cycle pulse at end of a complete frame
//   CRC_OK    : received CRC matched, valid with DONE
//   FRAME_ERR : one-cycle pulse when ACTIVE dropped mid-frame
module crc_serial_checker
    import crc_pkg::*;
#(
    parameter int                   DATA_BITS = 8,
    parameter int                   CRC_WIDTH = 8,
    parameter logic [CRC_WIDTH-1:0] SEED      = CRC8_SEED,
    parameter logic [CRC_WIDTH-1:0] TAPS      = CRC8_TAPS
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 SER_IN,
    input  logic                 ACTIVE,
    output logic [DATA_BITS-1:0] P_DATA,
    output logic                 DONE,
    output logic                 CRC_OK,
    output logic                 FRAME_ERR
);

    localparam int MAX_BITS = (DATA_BITS > CRC_WIDTH) ? DATA_BITS : CRC_WIDTH;
    localparam int CNT_W    = (MAX_BITS > 1) ? $clog2(MAX_BITS) : 1;
    localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(DATA_BITS - 1);
    localparam logic [CNT_W-1:0] LAST_CRC  = CNT_W'(CRC_WIDTH - 1);

    chk_state_e             state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [DATA_BITS-1:0]   payload_q, payload_d;
    logic                   mismatch_q, mismatch_d;
    logic [DATA_BITS-1:0]   p_data_d;
    logic                   done_d, crc_ok_d, frame_err_d;
    logic                   load_seed, feed_en, shift_en, bit_err;
    logic [CRC_WIDTH-1:0]   lfsr;

    crc_lfsr_core #(
        .WIDTH (CRC_WIDTH),
        .SEED  (SEED),
        .TAPS  (TAPS)
    ) u_lfsr (
        .clk       (CLK),
        .rst       (RST),
        .load_seed (load_seed),
        .feed_en   (feed_en),
        .feed_bit  (SER_IN),
        .shift_en  (shift_en),
        .lfsr      (lfsr)
    );

    // Every path into IDLE reloads the seed, so IDLE can consume payload
    // bit 0 immediately; that is what makes back-to-back frames bubble-free.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        payload_d   = payload_q;
        mismatch_d  = mismatch_q;
        p_data_d    = P_DATA;
        crc_ok_d    = CRC_OK;
        done_d      = 1'b0;
        frame_err_d = 1'b0;
        load_seed   = 1'b0;
        feed_en     = 1'b0;
        shift_en    = 1'b0;
        bit_err     = SER_IN ^ lfsr[0];
        case (state_q)
            ST_IDLE: begin
                cnt_d      = '0;
                mismatch_d = 1'b0;
                if (ACTIVE) begin
                    feed_en      = 1'b1;
                    payload_d[0] = SER_IN;
                    cnt_d        = CNT_W'(1);
                    state_d      = ST_PAYLOAD;
                end else begin
                    load_seed = 1'b1;
                end
            end
            ST_PAYLOAD: begin
                if (!ACTIVE) begin
                    frame_err_d = 1'b1;
                    load_seed   = 1'b1;
                    cnt_d       = '0;
                    state_d     = ST_IDLE;
                end else begin
                    feed_en          = 1'b1;
                    payload_d[cnt_q] = SER_IN;
                    if (cnt_q == LAST_DATA) begin
                        cnt_d   = '0;
                        state_d = ST_CHECK;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_CHECK: begin
                if (!ACTIVE) begin
                    frame_err_d = 1'b1;
                    load_seed   = 1'b1;
                    cnt_d       = '0;
                    state_d     = ST_IDLE;
                end else begin
                    shift_en   = 1'b1;
                    mismatch_d = mismatch_q | bit_err;
                    if (cnt_q == LAST_CRC) begin
                        done_d    = 1'b1;
                        crc_ok_d  = ~(mismatch_q | bit_err);
                        p_data_d  = payload_q;
                        load_seed = 1'b1;
                        cnt_d     = '0;
                        state_d   = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                load_seed = 1'b1;
                cnt_d     = '0;
                state_d   = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            payload_q  <= '0;
            mismatch_q <= 1'b0;
            P_DATA     <= '0;
            DONE       <= 1'b0;
            CRC_OK     <= 1'b0;
            FRAME_ERR  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            payload_q  <= payload_d;
            mismatch_q <= mismatch_d;
            P_DATA     <= p_data_d;
            DONE       <= done_d;
            CRC_OK     <= crc_ok_d;
            FRAME_ERR  <= frame_err_d;
        end
    end

endmodule
